axi_write_router: RTL

AXI_WRITE_ROUTER -- requirements
Module: axi_write_router

---
 rtl/axi_write_router.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_write_router.sv
// AXI write router: forwards one outstanding write (AW/W/B) from a master to the slave picked by aw_select.
// Optional `DECERR_SLAVE_EN: non-one-hot selects are answered locally with DECERR instead of going to slave 0.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module axi_write_router #(
  parameter int SLAVE_NUM = 3,
  parameter int ID_WIDTH  = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic [ID_WIDTH-1:0]           s_awid,
  input  logic [`ADDR_WIDTH-1:0]        s_awaddr,
  input  logic [7:0]                    s_awlen,
  input  logic                          s_awvalid,
  output logic                          s_awready,
  input  logic [SLAVE_NUM-1:0]          aw_select,
  output logic [ID_WIDTH-1:0]           m_awid,
  output logic [`ADDR_WIDTH-1:0]        m_awaddr,
  output logic [7:0]                    m_awlen,
  output logic [SLAVE_NUM-1:0]          m_awvalid,
  input  logic [SLAVE_NUM-1:0]          m_awready,
  input  logic [`DATA_WIDTH-1:0]        s_wdata,
  input  logic [`DATA_WIDTH/8-1:0]      s_wstrb,
  input  logic                          s_wlast,
  input  logic                          s_wvalid,
  output logic                          s_wready,
  output logic [`DATA_WIDTH-1:0]        m_wdata,
  output logic [`DATA_WIDTH/8-1:0]      m_wstrb,
  output logic                          m_wlast,
  output logic [SLAVE_NUM-1:0]          m_wvalid,
  input  logic [SLAVE_NUM-1:0]          m_wready,
  output logic [ID_WIDTH-1:0]           s_bid,
  output logic [1:0]                    s_bresp,
  output logic                          s_bvalid,
  input  logic                          s_bready,
  input  logic [SLAVE_NUM*ID_WIDTH-1:0] m_bid,
  input  logic [SLAVE_NUM*2-1:0]        m_bresp,
  input  logic [SLAVE_NUM-1:0]          m_bvalid,
  output logic [SLAVE_NUM-1:0]          m_bready
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    DATA     = 3'd2,
    RESP     = 3'd3
`ifdef DECERR_SLAVE_EN
    ,
    ERR_DATA = 3'd4,
    ERR_RESP = 3'd5
`endif
  } state_t;

  localparam logic [SLAVE_NUM-1:0] SEL_ONE = SLAVE_NUM'(1);

  state_t                   state_r, state_nxt_s;
  logic                     awready_r;
  logic [ID_WIDTH-1:0]      awid_r;
  logic [`ADDR_WIDTH-1:0]   awaddr_r;
  logic [7:0]               awlen_r;
  logic [SLAVE_NUM-1:0]     sel_r;
  logic [7:0]               beat_cnt_r;
  logic                     wlast_err_r;
  logic [ID_WIDTH-1:0]      bid_sel_s;
  logic [1:0]               bresp_sel_s;
  logic                     aw_hs_s;
  logic                     w_hs_s;

  function automatic logic is_onehot(input logic [SLAVE_NUM-1:0] v);
    return (v != '0) && ((v & (v - SEL_ONE)) == '0);
  endfunction

  assign aw_hs_s = s_awvalid & awready_r;
  assign w_hs_s  = s_wvalid & s_wready;

  // State register; awready tracks IDLE but stays low until the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r   <= IDLE;
      awready_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      awready_r <= (state_nxt_s == IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (aw_hs_s) begin
`ifdef DECERR_SLAVE_EN
          if (is_onehot(aw_select)) begin
            state_nxt_s = ADDR;
          end else begin
            state_nxt_s = ERR_DATA;
          end
`else
          state_nxt_s = ADDR;
`endif
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ADDR: begin
        if ((m_awready & sel_r) != '0) state_nxt_s = DATA;
        else state_nxt_s = ADDR;
      end
      DATA: begin
        if (w_hs_s && s_wlast) state_nxt_s = RESP;
        else state_nxt_s = DATA;
      end
      RESP: begin
        if (s_bvalid && s_bready) state_nxt_s = IDLE;
        else state_nxt_s = RESP;
      end
`ifdef DECERR_SLAVE_EN
      ERR_DATA: begin
        if (w_hs_s && s_wlast) state_nxt_s = ERR_RESP;
        else state_nxt_s = ERR_DATA;
      end
      ERR_RESP: begin
        if (s_bready) state_nxt_s = IDLE;
        else state_nxt_s = ERR_RESP;
      end
`endif
      default: state_nxt_s = IDLE;
    endcase
  end

  // AW capture; without the decode-error slave a bad select falls back to slave 0.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      awid_r   <= '0;
      awaddr_r <= '0;
      awlen_r  <= 8'd0;
      sel_r    <= '0;
    end else if (aw_hs_s) begin
      awid_r   <= s_awid;
      awaddr_r <= s_awaddr;
      awlen_r  <= s_awlen;
`ifdef DECERR_SLAVE_EN
      sel_r    <= aw_select;
`else
      sel_r    <= is_onehot(aw_select) ? aw_select : SEL_ONE;
`endif
    end
  end

  // Beat counter and sticky WLAST/AWLEN disagreement flag, both cleared while idle.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      beat_cnt_r  <= 8'd0;
      wlast_err_r <= 1'b0;
    end else if (state_r == IDLE) begin
      beat_cnt_r  <= 8'd0;
      wlast_err_r <= 1'b0;
    end else if ((state_r == DATA) && w_hs_s) begin
      beat_cnt_r <= beat_cnt_r + 8'd1;
      if (s_wlast != (beat_cnt_r == awlen_r)) wlast_err_r <= 1'b1;
    end
  end

  // B channel mux from the selected slave (sel_r is one-hot whenever it is used).
  always_comb begin
    bid_sel_s   = '0;
    bresp_sel_s = 2'b00;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      bid_sel_s   = bid_sel_s | (m_bid[i*ID_WIDTH +: ID_WIDTH] & {ID_WIDTH{sel_r[i]}});
      bresp_sel_s = bresp_sel_s | (m_bresp[i*2 +: 2] & {2{sel_r[i]}});
    end
  end

  // Output decode per state.
  always_comb begin
    s_awready = awready_r;
    m_awid    = awid_r;
    m_awaddr  = awaddr_r;
    m_awlen   = awlen_r;
    m_awvalid = '0;
    m_wdata   = s_wdata;
    m_wstrb   = s_wstrb;
    m_wlast   = s_wlast;
    m_wvalid  = '0;
    s_wready  = 1'b0;
    m_bready  = '0;
    s_bvalid  = 1'b0;
    s_bid     = '0;
    s_bresp   = 2'b00;
    case (state_r)
      ADDR: m_awvalid = sel_r;
      DATA: begin
        m_wvalid = sel_r & {SLAVE_NUM{s_wvalid}};
        s_wready = |(m_wready & sel_r);
      end
      RESP: begin
        s_bvalid = |(m_bvalid & sel_r);
        m_bready = sel_r & {SLAVE_NUM{s_bready}};
        s_bid    = bid_sel_s;
        s_bresp  = bresp_sel_s;
      end
`ifdef DECERR_SLAVE_EN
      ERR_DATA: s_wready = 1'b1;
      ERR_RESP: begin
        s_bvalid = 1'b1;
        s_bresp  = 2'b11;
        s_bid    = awid_r;
      end
`endif
      default: s_awready = awready_r;
    endcase
  end

endmodule
